mono_readout_tx: RTL and testbench

MONO_READOUT_TX -- requirements
Module: mono_readout_tx

---
 rtl/mono_readout_tx.sv | 126 ++++++++++++
 tb/tb_mono_readout_tx.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mono_readout_tx.sv
// Hit FIFO plus serial readout: READ edge pops a 26-bit word, sent MSB first.
// Define MONO_READOUT_TX_GRAY_EN to Gray-encode the LE/TE fields on load.
module mono_readout_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int WORD_BITS  = 26
) (
  input  logic                 RX_CLK,
  input  logic                 RX_nRST,
  input  logic                 RX_READ,
  input  logic                 RX_FREEZE,
  output logic                 RX_TOKEN,
  output logic                 RX_DATA,
  input  logic                 HIT_WR,
  input  logic [WORD_BITS-1:0] HIT_DATA,
  output logic [7:0]           LOST_CNT,
  output logic                 READ_ERR
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [WORD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [AW:0]          wr_ptr_d, rd_ptr_d;
  logic [WORD_BITS-1:0] sreg;
  logic [4:0]           bit_cnt;
  logic                 read_q;
  logic                 empty, full;
  logic                 read_edge;
  logic                 pop, push, lose;

  function automatic logic [WORD_BITS-1:0] encode(
    input logic [WORD_BITS-1:0] w
  );
`ifdef MONO_READOUT_TX_GRAY_EN
    encode = {w[25:12],
              w[11:6] ^ {1'b0, w[11:7]},
              w[5:0]  ^ {1'b0, w[5:1]}};
`else
    encode = w;
`endif
  endfunction

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign read_edge = RX_READ && !read_q;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign push = HIT_WR && !RX_FREEZE && (!full || pop);
  assign lose = HIT_WR && !push;

  assign wr_ptr_d = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr + {{AW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_edge && !empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:  state_d = SHIFT;
      SHIFT: if (bit_cnt == 5'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= HIT_DATA;
  end

  always_ff @(posedge RX_CLK) begin
    if (!RX_nRST) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sreg     <= '0;
      bit_cnt  <= '0;
      read_q   <= 1'b0;
      RX_TOKEN <= 1'b0;
      RX_DATA  <= 1'b0;
      LOST_CNT <= '0;
      READ_ERR <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr   <= wr_ptr_d;
      rd_ptr   <= rd_ptr_d;
      read_q   <= RX_READ;
      RX_TOKEN <= (wr_ptr_d != rd_ptr_d);
      if (lose && LOST_CNT != 8'hFF)
        LOST_CNT <= LOST_CNT + 8'd1;
      if (read_edge && (state_q != IDLE || empty))
        READ_ERR <= 1'b1;
      unique case (state_q)
        IDLE: begin
          RX_DATA <= 1'b0;
          if (pop) sreg <= encode(mem[rd_ptr[AW-1:0]]);
        end
        LOAD: begin
          RX_DATA <= sreg[WORD_BITS-1];
          sreg    <= {sreg[WORD_BITS-2:0], 1'b0};
          bit_cnt <= 5'd24;
        end
        SHIFT: begin
          RX_DATA <= sreg[WORD_BITS-1];
          sreg    <= {sreg[WORD_BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt - 5'd1;
        end
        default: RX_DATA <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mono_readout_tx.sv
// Directed self-checking bench for mono_readout_tx.
// Define MONO_READOUT_TX_GRAY_EN here too to check the Gray build.
module tb_mono_readout_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_read;
  logic        rx_freeze;
  logic        rx_token;
  logic        rx_data;
  logic        hit_wr;
  logic [25:0] hit_data;
  logic [7:0]  lost_cnt;
  logic        read_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mono_readout_tx #(.FIFO_DEPTH(16), .WORD_BITS(26)) dut (
    .RX_CLK   (clk),
    .RX_nRST  (rst_n),
    .RX_READ  (rx_read),
    .RX_FREEZE(rx_freeze),
    .RX_TOKEN (rx_token),
    .RX_DATA  (rx_data),
    .HIT_WR   (hit_wr),
    .HIT_DATA (hit_data),
    .LOST_CNT (lost_cnt),
    .READ_ERR (read_err)
  );

  function automatic logic [5:0] gray6(input logic [5:0] b);
    logic [5:0] g;
    g[5] = b[5];
    for (int i = 0; i < 5; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [25:0] exp_word(input logic [25:0] w);
`ifdef MONO_READOUT_TX_GRAY_EN
    return {w[25:12], gray6(w[11:6]), gray6(w[5:0])};
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_read = 1'b0;
    rx_freeze = 1'b0;
    hit_wr = 1'b0;
    hit_data = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic write_hit(input logic [25:0] w);
    hit_wr = 1'b1;
    hit_data = w;
    tick();
    hit_wr = 1'b0;
  endtask

  task automatic read_word(input int pulse_at, output logic [25:0] w,
                           output logic tok, output logic d_load);
    rx_read = 1'b1;
    tick();
    tok = rx_token;
    d_load = rx_data;
    rx_read = 1'b0;
    tick();
    for (int i = 0; i < 26; i++) begin
      w[25-i] = rx_data;
      rx_read = (i == pulse_at);
      tick();
    end
    rx_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    rx_read = 1'b0;
    rx_freeze = 1'b0;
    hit_wr = 1'b0;
    hit_data = '0;
    tick();
    do_reset();
    tests++;
    if ({rx_token, rx_data, read_err} !== 3'b000) begin
      $display("FAIL reset_flags got %b want 000",
               {rx_token, rx_data, read_err});
      fails++;
    end
    tests++;
    if (lost_cnt !== 8'd0) begin
      $display("FAIL reset_lost got %0d want 0", lost_cnt);
      fails++;
    end
  endtask

  task automatic test_basic();
    logic [25:0] w;
    logic tok, dl;
    do_reset();
    write_hit(26'h2A5_5A5A);
    tests++;
    if (rx_token !== 1'b1) begin
      $display("FAIL basic_token got %b want 1", rx_token);
      fails++;
    end
    read_word(-1, w, tok, dl);
    tests++;
    if (tok !== 1'b0) begin
      $display("FAIL basic_token_pop got %b want 0", tok);
      fails++;
    end
    tests++;
    if (dl !== 1'b0) begin
      $display("FAIL basic_load_data got %b want 0", dl);
      fails++;
    end
    tests++;
    if (w !== exp_word(26'h2A5_5A5A)) begin
      $display("FAIL basic_word got %h want %h", w,
               exp_word(26'h2A5_5A5A));
      fails++;
    end
    tests++;
    if ({rx_data, read_err} !== 2'b00) begin
      $display("FAIL basic_idle got %b want 00", {rx_data, read_err});
      fails++;
    end
  endtask

  task automatic test_overflow();
    logic [25:0] w;
    logic tok, dl;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 18; i++) write_hit(26'h100000 + 26'(i * 3 + 1));
    tests++;
    if (lost_cnt !== 8'd2) begin
      $display("FAIL ovf_lost got %0d want 2", lost_cnt);
      fails++;
    end
    for (int i = 0; i < 16; i++) begin
      read_word(-1, w, tok, dl);
      if (w !== exp_word(26'h100000 + 26'(i * 3 + 1))) bad++;
    end
    tests++;
    if (bad != 0) begin
      $display("FAIL ovf_order got %0d bad words want 0", bad);
      fails++;
    end
    tests++;
    if ({rx_token, read_err} !== 2'b00) begin
      $display("FAIL ovf_drained got %b want 00", {rx_token, read_err});
      fails++;
    end
  endtask

  task automatic test_full_rw();
    logic [25:0] w;
    logic tok, dl;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 16; i++) write_hit(26'h3000 + 26'(i));
    rx_read = 1'b1;
    hit_wr = 1'b1;
    hit_data = 26'h3ABCDEF;
    tick();
    rx_read = 1'b0;
    hit_wr = 1'b0;
    for (int i = 0; i < 27; i++) tick();
    tests++;
    if (lost_cnt !== 8'd0) begin
      $display("FAIL fullrw_lost got %0d want 0", lost_cnt);
      fails++;
    end
    for (int i = 1; i < 16; i++) begin
      read_word(-1, w, tok, dl);
      if (w !== exp_word(26'h3000 + 26'(i))) bad++;
    end
    read_word(-1, w, tok, dl);
    if (w !== exp_word(26'h3ABCDEF)) bad++;
    tests++;
    if (bad != 0) begin
      $display("FAIL fullrw_order got %0d bad words want 0", bad);
      fails++;
    end
  endtask

  task automatic test_freeze();
    logic [25:0] w;
    logic tok, dl;
    do_reset();
    write_hit(26'h0123456);
    rx_freeze = 1'b1;
    for (int i = 0; i < 3; i++) write_hit(26'h3FF0000 + 26'(i));
    rx_freeze = 1'b0;
    tests++;
    if (lost_cnt !== 8'd3) begin
      $display("FAIL freeze_lost got %0d want 3", lost_cnt);
      fails++;
    end
    read_word(-1, w, tok, dl);
    tests++;
    if (w !== exp_word(26'h0123456) || tok !== 1'b0) begin
      $display("FAIL freeze_fifo got %h/%b want %h/0", w, tok,
               exp_word(26'h0123456));
      fails++;
    end
  endtask

  task automatic test_read_err();
    logic [25:0] w;
    logic tok, dl;
    do_reset();
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
    tick();
    tests++;
    if ({read_err, rx_data, rx_token} !== 3'b100) begin
      $display("FAIL err_empty got %b want 100",
               {read_err, rx_data, rx_token});
      fails++;
    end
    tick();
    tests++;
    if (read_err !== 1'b1) begin
      $display("FAIL err_sticky got %b want 1", read_err);
      fails++;
    end
    do_reset();
    write_hit(26'h2C3_96A5);
    read_word(8, w, tok, dl);
    tests++;
    if (read_err !== 1'b1) begin
      $display("FAIL err_shift got %b want 1", read_err);
      fails++;
    end
    tests++;
    if (w !== exp_word(26'h2C3_96A5)) begin
      $display("FAIL err_word got %h want %h", w,
               exp_word(26'h2C3_96A5));
      fails++;
    end
  endtask

  task automatic test_gray();
    logic [25:0] w, in_w;
    logic tok, dl;
    logic [5:0] le_x, te_x;
    do_reset();
    in_w = {6'd1, 8'd2, 6'd5, 6'd63};
`ifdef MONO_READOUT_TX_GRAY_EN
    le_x = 6'b000111;
    te_x = 6'b100000;
`else
    le_x = 6'd5;
    te_x = 6'd63;
`endif
    write_hit(in_w);
    read_word(-1, w, tok, dl);
    tests++;
    if (w !== {6'd1, 8'd2, le_x, te_x}) begin
      $display("FAIL gray_word got %h want %h", w,
               {6'd1, 8'd2, le_x, te_x});
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rx_freeze = 1'b1;
    write_hit(26'h0);
    rx_freeze = 1'b0;
    write_hit(26'h3FFFFFF);
    write_hit(26'h3FFFFFF);
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    rst_n = 1'b0;
    tick();
    tests++;
    if ({rx_data, rx_token, read_err} !== 3'b000 || lost_cnt !== 8'd0) begin
      $display("FAIL rstmid got %b/%0d want 000/0",
               {rx_data, rx_token, read_err}, lost_cnt);
      fails++;
    end
    rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (rx_data !== 1'b0) begin
      $display("FAIL rstmid_partial got %b want 0", rx_data);
      fails++;
    end
    rx_read = 1'b1;
    tick();
    rx_read = 1'b0;
    tick();
    tests++;
    if ({read_err, rx_data} !== 2'b10) begin
      $display("FAIL rstmid_idle got %b want 10", {read_err, rx_data});
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_rw();
    test_freeze();
    test_read_err();
    test_gray();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
